// File: rtl/flow_meter_pkg.sv
// Shared types and helpers for the AXI-Stream flow meter.
package flow_meter_pkg;

    typedef enum logic [0:0] {
        ST_OFF = 1'b0,
        ST_RUN = 1'b1
    } meter_state_t;

    // Bytes carried by one accepted beat; an over-large empty count on the last beat still counts one byte.
    function automatic int unsigned beat_bytes(input int unsigned bytes_per_beat,
                                               input logic        last,
                                               input int unsigned mty);
        int unsigned n;
        if (!last) begin
            n = bytes_per_beat;
        end else if (mty >= bytes_per_beat) begin
            n = 32'd1;
        end else begin
            n = bytes_per_beat - mty;
        end
        return n;
    endfunction

endpackage

// File: rtl/axis_skid_buf.sv
// Two-entry skid buffer: output register plus one skid register, ready driven from a flop.
module axis_skid_buf #(
    parameter int C_WIDTH = 262
) (
    input  logic               aclk,
    input  logic               aresetn,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [C_WIDTH-1:0] s_data,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [C_WIDTH-1:0] m_data
);

    logic               out_valid_r, out_valid_nxt_s;
    logic               skid_valid_r, skid_valid_nxt_s;
    logic               ready_r;
    logic [C_WIDTH-1:0] out_data_r, out_data_nxt_s;
    logic [C_WIDTH-1:0] skid_data_r, skid_data_nxt_s;
    logic               in_hs_s;
    logic               out_free_s;

    // Next-state for both entries; the skid entry only fills while the output is stalled.
    always_comb begin
        in_hs_s          = s_valid && ready_r;
        out_free_s       = !out_valid_r || m_ready;
        out_valid_nxt_s  = out_valid_r;
        out_data_nxt_s   = out_data_r;
        skid_valid_nxt_s = skid_valid_r;
        skid_data_nxt_s  = skid_data_r;
        if (out_free_s) begin
            if (skid_valid_r) begin
                out_valid_nxt_s  = 1'b1;
                out_data_nxt_s   = skid_data_r;
                skid_valid_nxt_s = 1'b0;
            end else if (in_hs_s) begin
                out_valid_nxt_s = 1'b1;
                out_data_nxt_s  = s_data;
            end else begin
                out_valid_nxt_s = 1'b0;
            end
        end else if (in_hs_s) begin
            skid_valid_nxt_s = 1'b1;
            skid_data_nxt_s  = s_data;
        end else begin
            skid_valid_nxt_s = skid_valid_r;
        end
    end

    // Entry registers; ready drops only when the skid entry (and hence both) will be full.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            out_valid_r  <= 1'b0;
            out_data_r   <= {C_WIDTH{1'b0}};
            skid_valid_r <= 1'b0;
            skid_data_r  <= {C_WIDTH{1'b0}};
            ready_r      <= 1'b0;
        end else begin
            out_valid_r  <= out_valid_nxt_s;
            out_data_r   <= out_data_nxt_s;
            skid_valid_r <= skid_valid_nxt_s;
            skid_data_r  <= skid_data_nxt_s;
            ready_r      <= !skid_valid_nxt_s;
        end
    end

    assign s_ready = ready_r;
    assign m_valid = out_valid_r;
    assign m_data  = out_data_r;

endmodule

// File: rtl/axis_flow_meter.sv
// AXI-Stream pass-through with windowed byte/packet rate metering.
// Optional peak-rate tracking is built when FLOW_METER_PEAK_EN is defined.
module axis_flow_meter
    import flow_meter_pkg::*;
#(
    parameter int C_DATA_WIDTH    = 256,
    parameter int C_MTY_WIDTH     = 5,
    parameter int C_WINDOW_CYCLES = 156250000,
    parameter int C_CNT_WIDTH     = 48
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic                    s_axis_tvalid,
    input  logic [C_DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                    s_axis_tlast,
    input  logic [C_MTY_WIDTH-1:0]  s_axis_tuser_mty,
    output logic                    s_axis_tready,
    output logic                    m_axis_tvalid,
    output logic [C_DATA_WIDTH-1:0] m_axis_tdata,
    output logic                    m_axis_tlast,
    output logic [C_MTY_WIDTH-1:0]  m_axis_tuser_mty,
    input  logic                    m_axis_tready,
    input  logic                    meter_en,
`ifdef FLOW_METER_PEAK_EN
    input  logic                    peak_clr,
    output logic [C_CNT_WIDTH-1:0]  peak_bytes,
`endif
    output logic                    rate_valid,
    output logic [C_CNT_WIDTH-1:0]  rate_bytes,
    output logic [C_CNT_WIDTH-1:0]  rate_pkts
);

    localparam int C_BYTES_PER_BEAT = C_DATA_WIDTH / 8;
    localparam int C_PAYLOAD_W      = C_DATA_WIDTH + C_MTY_WIDTH + 1;
    localparam int C_TIMER_W        = $clog2(C_WINDOW_CYCLES);
    localparam logic [C_TIMER_W-1:0] C_TIMER_LAST = C_TIMER_W'(C_WINDOW_CYCLES - 1);

    logic [C_PAYLOAD_W-1:0] m_payload_s;
    logic                   in_hs_s;
    logic [C_CNT_WIDTH-1:0] beat_bytes_s;
    logic [C_CNT_WIDTH:0]   byte_sum_s, pkt_sum_s;
    logic [C_CNT_WIDTH-1:0] byte_sat_s, pkt_sat_s;
    meter_state_t           state_r, state_nxt_s;
    logic                   run_s, close_s;
    logic [C_TIMER_W-1:0]   timer_r;
    logic [C_CNT_WIDTH-1:0] acc_bytes_r, acc_pkts_r;
    logic                   rate_valid_r;
    logic [C_CNT_WIDTH-1:0] rate_bytes_r, rate_pkts_r;

    axis_skid_buf #(
        .C_WIDTH (C_PAYLOAD_W)
    ) u_skid (
        .aclk    (aclk),
        .aresetn (aresetn),
        .s_valid (s_axis_tvalid),
        .s_ready (s_axis_tready),
        .s_data  ({s_axis_tlast, s_axis_tuser_mty, s_axis_tdata}),
        .m_valid (m_axis_tvalid),
        .m_ready (m_axis_tready),
        .m_data  (m_payload_s)
    );

    assign {m_axis_tlast, m_axis_tuser_mty, m_axis_tdata} = m_payload_s;

    // This cycle's contribution, added to the accumulators with saturation.
    always_comb begin
        in_hs_s = s_axis_tvalid && s_axis_tready;
        if (in_hs_s) begin
            beat_bytes_s = C_CNT_WIDTH'(beat_bytes(C_BYTES_PER_BEAT, s_axis_tlast, 32'(s_axis_tuser_mty)));
        end else begin
            beat_bytes_s = {C_CNT_WIDTH{1'b0}};
        end
        byte_sum_s = {1'b0, acc_bytes_r} + {1'b0, beat_bytes_s};
        pkt_sum_s  = {1'b0, acc_pkts_r} + {{C_CNT_WIDTH{1'b0}}, in_hs_s && s_axis_tlast};
        byte_sat_s = byte_sum_s[C_CNT_WIDTH] ? {C_CNT_WIDTH{1'b1}} : byte_sum_s[C_CNT_WIDTH-1:0];
        pkt_sat_s  = pkt_sum_s[C_CNT_WIDTH]  ? {C_CNT_WIDTH{1'b1}} : pkt_sum_s[C_CNT_WIDTH-1:0];
    end

    // Control FSM state register.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_r <= ST_OFF;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Control FSM next state.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_OFF:  state_nxt_s = meter_en ? ST_RUN : ST_OFF;
            ST_RUN:  state_nxt_s = meter_en ? ST_RUN : ST_OFF;
            default: state_nxt_s = ST_OFF;
        endcase
    end

    // Control FSM outputs; a RUN cycle with meter_en low discards the partial window.
    always_comb begin
        run_s   = 1'b0;
        close_s = 1'b0;
        case (state_r)
            ST_OFF: begin
                run_s   = 1'b0;
                close_s = 1'b0;
            end
            ST_RUN: begin
                run_s   = meter_en;
                close_s = meter_en && (timer_r == C_TIMER_LAST);
            end
            default: begin
                run_s   = 1'b0;
                close_s = 1'b0;
            end
        endcase
    end

    // Window timer, accumulators and published rate.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            timer_r      <= {C_TIMER_W{1'b0}};
            acc_bytes_r  <= {C_CNT_WIDTH{1'b0}};
            acc_pkts_r   <= {C_CNT_WIDTH{1'b0}};
            rate_valid_r <= 1'b0;
            rate_bytes_r <= {C_CNT_WIDTH{1'b0}};
            rate_pkts_r  <= {C_CNT_WIDTH{1'b0}};
        end else if (close_s) begin
            timer_r      <= {C_TIMER_W{1'b0}};
            acc_bytes_r  <= {C_CNT_WIDTH{1'b0}};
            acc_pkts_r   <= {C_CNT_WIDTH{1'b0}};
            rate_valid_r <= 1'b1;
            rate_bytes_r <= byte_sat_s;
            rate_pkts_r  <= pkt_sat_s;
        end else if (run_s) begin
            timer_r      <= timer_r + C_TIMER_W'(1'b1);
            acc_bytes_r  <= byte_sat_s;
            acc_pkts_r   <= pkt_sat_s;
            rate_valid_r <= 1'b0;
        end else begin
            timer_r      <= {C_TIMER_W{1'b0}};
            acc_bytes_r  <= {C_CNT_WIDTH{1'b0}};
            acc_pkts_r   <= {C_CNT_WIDTH{1'b0}};
            rate_valid_r <= 1'b0;
        end
    end

    assign rate_valid = rate_valid_r;
    assign rate_bytes = rate_bytes_r;
    assign rate_pkts  = rate_pkts_r;

`ifdef FLOW_METER_PEAK_EN
    logic [C_CNT_WIDTH-1:0] peak_bytes_r;

    // Highest closed-window byte count; a clear beats a same-cycle update.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            peak_bytes_r <= {C_CNT_WIDTH{1'b0}};
        end else if (peak_clr) begin
            peak_bytes_r <= {C_CNT_WIDTH{1'b0}};
        end else if (close_s && (byte_sat_s > peak_bytes_r)) begin
            peak_bytes_r <= byte_sat_s;
        end else begin
            peak_bytes_r <= peak_bytes_r;
        end
    end

    assign peak_bytes = peak_bytes_r;
`endif

endmodule

// File: tb/tb_axis_flow_meter.sv
// Randomized self-checking bench for axis_flow_meter with a scoreboard and window model.
module tb_axis_flow_meter;

    localparam int DW  = 256;
    localparam int MW  = 6;
    localparam int W   = 100;
    localparam int CW  = 48;
    localparam int BPB = DW / 8;
    localparam int PW  = DW + MW + 1;

    typedef logic [PW-1:0] pl_t;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic          s_axis_tvalid = 1'b0;
    logic [DW-1:0] s_axis_tdata = '0;
    logic          s_axis_tlast = 1'b0;
    logic [MW-1:0] s_axis_tuser_mty = '0;
    logic          s_axis_tready;
    logic          m_axis_tvalid;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tlast;
    logic [MW-1:0] m_axis_tuser_mty;
    logic          m_axis_tready = 1'b1;
    logic          meter_en = 1'b0;
    logic          rate_valid;
    logic [CW-1:0] rate_bytes;
    logic [CW-1:0] rate_pkts;
`ifdef FLOW_METER_PEAK_EN
    logic          peak_clr = 1'b0;
    logic [CW-1:0] peak_bytes;
`endif

    axis_flow_meter #(
        .C_DATA_WIDTH    (DW),
        .C_MTY_WIDTH     (MW),
        .C_WINDOW_CYCLES (W),
        .C_CNT_WIDTH     (CW)
    ) dut (
        .aclk             (aclk),
        .aresetn          (aresetn),
        .s_axis_tvalid    (s_axis_tvalid),
        .s_axis_tdata     (s_axis_tdata),
        .s_axis_tlast     (s_axis_tlast),
        .s_axis_tuser_mty (s_axis_tuser_mty),
        .s_axis_tready    (s_axis_tready),
        .m_axis_tvalid    (m_axis_tvalid),
        .m_axis_tdata     (m_axis_tdata),
        .m_axis_tlast     (m_axis_tlast),
        .m_axis_tuser_mty (m_axis_tuser_mty),
        .m_axis_tready    (m_axis_tready),
        .meter_en         (meter_en),
`ifdef FLOW_METER_PEAK_EN
        .peak_clr         (peak_clr),
        .peak_bytes       (peak_bytes),
`endif
        .rate_valid       (rate_valid),
        .rate_bytes       (rate_bytes),
        .rate_pkts        (rate_pkts)
    );

    always #5 aclk = ~aclk;

    int  total = 0;
    int  bad = 0;
    pl_t sb[$];
    bit  src_on = 1'b0, src_rand = 1'b0, rdy_rand = 1'b0;
    bit  hs_last = 1'b0, rst_prev = 1'b0, prev_stall = 1'b0, exp_pulse = 1'b0;
    pl_t prev_pl;
    int  beat_idx = 0, pkt_len = 4;
    bit  m_run = 1'b0;
    int  m_pos = 0;
    longint unsigned m_acc_b = 0, m_acc_p = 0;
    logic [CW-1:0] exp_rb = '0, exp_rp = '0, exp_peak = '0;

    function automatic longint unsigned exp_bytes(input bit last, input int mty);
        if (!last) return longint'(BPB);
        if (mty >= BPB) return 1;
        return longint'(BPB - mty);
    endfunction

    // Scoreboard, flow-control checks and window model, evaluated at the falling edge.
    always @(negedge aclk) begin
        pl_t cur;
        pl_t want;
        bit  closing;
        cur = {m_axis_tlast, m_axis_tuser_mty, m_axis_tdata};
        closing = 1'b0;
        if (!aresetn) begin
            if (!rst_prev) begin
                total++;
                if (m_axis_tvalid !== 1'b0 || s_axis_tready !== 1'b0 || rate_valid !== 1'b0 ||
                    rate_bytes !== '0 || rate_pkts !== '0 || cur !== '0) begin
                    bad++;
                    $display("FAIL reset_state: tvalid=%b tready=%b rate_valid=%b bytes=%0d pkts=%0d, want all zero",
                             m_axis_tvalid, s_axis_tready, rate_valid, rate_bytes, rate_pkts);
                end
            end
            sb.delete();
            m_run = 1'b0; m_pos = 0; m_acc_b = 0; m_acc_p = 0;
            exp_pulse = 1'b0; exp_rb = '0; exp_rp = '0; exp_peak = '0;
            prev_stall = 1'b0; hs_last = 1'b0;
        end else begin
            total++;
            if (s_axis_tready !== (rst_prev && sb.size() < 2)) begin
                bad++;
                $display("FAIL s_tready: got %b want %b (held=%0d)", s_axis_tready, rst_prev && sb.size() < 2, sb.size());
            end
            total++;
            if (rate_valid !== exp_pulse || rate_bytes !== exp_rb || rate_pkts !== exp_rp) begin
                bad++;
                $display("FAIL rate_out: got v=%b b=%0d p=%0d want v=%b b=%0d p=%0d",
                         rate_valid, rate_bytes, rate_pkts, exp_pulse, exp_rb, exp_rp);
            end
`ifdef FLOW_METER_PEAK_EN
            total++;
            if (peak_bytes !== exp_peak) begin
                bad++;
                $display("FAIL peak_bytes: got %0d want %0d", peak_bytes, exp_peak);
            end
`endif
            if (prev_stall) begin
                total++;
                if (m_axis_tvalid !== 1'b1 || cur !== prev_pl) begin
                    bad++;
                    $display("FAIL stall_hold: got valid=%b data=%h want valid=1 data=%h", m_axis_tvalid, cur, prev_pl);
                end
            end
            if (m_axis_tvalid && m_axis_tready) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL out_beat: got unexpected beat %h want none", cur);
                end else begin
                    want = sb.pop_front();
                    if (cur !== want) begin
                        bad++;
                        $display("FAIL out_beat: got %h want %h", cur, want);
                    end
                end
            end
            hs_last = s_axis_tvalid && s_axis_tready;
            if (hs_last) sb.push_back({s_axis_tlast, s_axis_tuser_mty, s_axis_tdata});
            exp_pulse = 1'b0;
            if (m_run && meter_en) begin
                if (hs_last) begin
                    m_acc_b += exp_bytes(s_axis_tlast, int'(s_axis_tuser_mty));
                    if (s_axis_tlast) m_acc_p++;
                end
                if (m_pos == W - 1) begin
                    exp_rb = CW'(m_acc_b); exp_rp = CW'(m_acc_p); exp_pulse = 1'b1; closing = 1'b1;
                    m_acc_b = 0; m_acc_p = 0; m_pos = 0;
                end else begin
                    m_pos++;
                end
            end else begin
                m_acc_b = 0; m_acc_p = 0; m_pos = 0;
            end
            m_run = meter_en;
`ifdef FLOW_METER_PEAK_EN
            if (peak_clr) exp_peak = '0;
            else if (closing && exp_rb > exp_peak) exp_peak = exp_rb;
`endif
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_pl = cur;
        end
        rst_prev = aresetn;
    end

    task automatic drive();
        bit last;
        if (!s_axis_tvalid || hs_last) begin
            if (src_on && (!src_rand || $urandom_range(0, 3) != 0)) begin
                if (beat_idx == 0) pkt_len = src_rand ? int'($urandom_range(1, 5)) : 4;
                last = (beat_idx == pkt_len - 1);
                s_axis_tvalid = 1'b1;
                for (int i = 0; i < DW / 32; i++) s_axis_tdata[i*32 +: 32] = $urandom;
                s_axis_tlast = last;
                if (last) s_axis_tuser_mty = src_rand ? MW'($urandom_range(0, 63)) : MW'(5);
                else s_axis_tuser_mty = MW'($urandom);
                beat_idx = last ? 0 : beat_idx + 1;
            end else begin
                s_axis_tvalid = 1'b0;
            end
        end
        m_axis_tready = rdy_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
        drive();
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        repeat (3) step();
        #1;
        total++;
        if (s_axis_tready !== 1'b0 || m_axis_tvalid !== 1'b0 || rate_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_hold: got tready=%b tvalid=%b rate_valid=%b want 0 0 0", s_axis_tready, m_axis_tvalid, rate_valid);
        end
        aresetn = 1'b1;
        step();
        #1;
        total++;
        if (s_axis_tready !== 1'b1) begin
            bad++;
            $display("FAIL ready_after_reset: got %b want 1", s_axis_tready);
        end
    endtask

    task automatic test_rate();
        int n_pulse = 0;
        int last_k = 0;
        src_on = 1'b1; src_rand = 1'b0; rdy_rand = 1'b0; meter_en = 1'b1;
        for (int k = 0; k < 450; k++) begin
            step();
            #1;
            if (rate_valid === 1'b1) begin
                n_pulse++;
                if (n_pulse >= 2) begin
                    total++;
                    if (rate_bytes !== 48'd3075 || rate_pkts !== 48'd25 || (k - last_k) != W) begin
                        bad++;
                        $display("FAIL window_rate: got bytes=%0d pkts=%0d spacing=%0d want 3075 25 %0d",
                                 rate_bytes, rate_pkts, k - last_k, W);
                    end
                end
                last_k = k;
            end
        end
        total++;
        if (n_pulse < 4) begin
            bad++;
            $display("FAIL window_count: got %0d pulses want 4", n_pulse);
        end
    endtask

    task automatic test_back_to_back();
        src_on = 1'b1; src_rand = 1'b1; rdy_rand = 1'b1; meter_en = 1'b1;
        repeat (800) step();
        src_on = 1'b0; rdy_rand = 1'b0;
        repeat (10) step();
        #1;
        total++;
        if (sb.size() != 0 || m_axis_tvalid !== 1'b0) begin
            bad++;
            $display("FAIL drain: got %0d beats outstanding valid=%b want 0 0", sb.size(), m_axis_tvalid);
        end
    endtask

    task automatic test_terminal_beat();
        bit found = 1'b0;
        src_on = 1'b0; rdy_rand = 1'b0; meter_en = 1'b0;
        repeat (4) step();
        meter_en = 1'b1;
        for (int k = 0; k < 3 * W; k++) begin
            step();
            if (m_pos == W - 1) begin found = 1'b1; break; end
        end
        s_axis_tvalid = 1'b1; s_axis_tlast = 1'b1; s_axis_tuser_mty = MW'(40);
        s_axis_tdata = {DW{1'b1}};
        step();
        #1;
        total++;
        if (!found || rate_valid !== 1'b1 || rate_bytes !== 48'd1 || rate_pkts !== 48'd1) begin
            bad++;
            $display("FAIL terminal_beat: got found=%b v=%b bytes=%0d pkts=%0d want 1 1 1 1", found, rate_valid, rate_bytes, rate_pkts);
        end
        found = 1'b0;
        for (int k = 1; k <= 2 * W; k++) begin
            step();
            #1;
            if (rate_valid === 1'b1) begin
                found = 1'b1;
                total++;
                if (k != W || rate_pkts !== 48'd0 || rate_bytes !== 48'd0) begin
                    bad++;
                    $display("FAIL idle_window: got at=%0d pkts=%0d bytes=%0d want %0d 0 0", k, rate_pkts, rate_bytes, W);
                end
                break;
            end
        end
        total++;
        if (!found) begin
            bad++;
            $display("FAIL idle_window_timeout: got no pulse want pulse");
        end
    endtask

    task automatic test_meter_en();
        bit found = 1'b0;
        int first_k = -1;
        logic [CW-1:0] held_b, held_p;
        src_on = 1'b1; src_rand = 1'b1; rdy_rand = 1'b0; meter_en = 1'b1;
        for (int k = 0; k < 3 * W; k++) begin
            step();
            if (m_pos == 50) begin found = 1'b1; break; end
        end
        meter_en = 1'b0;
        held_b = exp_rb; held_p = exp_rp;
        for (int k = 0; k < 5; k++) begin
            step();
            #1;
            total++;
            if (!found || rate_valid !== 1'b0 || rate_bytes !== held_b || rate_pkts !== held_p) begin
                bad++;
                $display("FAIL meter_off_hold: got v=%b b=%0d p=%0d want 0 %0d %0d", rate_valid, rate_bytes, rate_pkts, held_b, held_p);
            end
        end
        meter_en = 1'b1;
        for (int k = 1; k <= W + 5; k++) begin
            step();
            #1;
            if (rate_valid === 1'b1) begin first_k = k; break; end
        end
        total++;
        if (first_k != W + 1) begin
            bad++;
            $display("FAIL restart_window: got first pulse at %0d want %0d", first_k, W + 1);
        end
    endtask

    task automatic test_mid_reset();
        src_on = 1'b1; src_rand = 1'b0; rdy_rand = 1'b1; meter_en = 1'b1;
        repeat (37) step();
        aresetn = 1'b0;
        repeat (2) step();
        #1;
        total++;
        if (m_axis_tvalid !== 1'b0 || rate_valid !== 1'b0 || rate_bytes !== '0 || s_axis_tready !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset: got valid=%b rv=%b rb=%0d rdy=%b want 0 0 0 0", m_axis_tvalid, rate_valid, rate_bytes, s_axis_tready);
        end
        aresetn = 1'b1;
        step();
        #1;
        total++;
        if (s_axis_tready !== 1'b1) begin
            bad++;
            $display("FAIL mid_reset_ready: got %b want 1", s_axis_tready);
        end
        repeat (300) step();
    endtask

`ifdef FLOW_METER_PEAK_EN
    task automatic test_peak();
        bit found = 1'b0;
        src_on = 1'b1; src_rand = 1'b1; rdy_rand = 1'b0; meter_en = 1'b1;
        repeat (3 * W) step();
        for (int k = 0; k < 3 * W; k++) begin
            step();
            if (m_pos == W - 1) begin found = 1'b1; break; end
        end
        peak_clr = 1'b1;
        step();
        peak_clr = 1'b0;
        #1;
        total++;
        if (!found || peak_bytes !== '0 || rate_valid !== 1'b1) begin
            bad++;
            $display("FAIL peak_clr_on_close: got found=%b peak=%0d rv=%b want 1 0 1", found, peak_bytes, rate_valid);
        end
        repeat (2 * W) step();
    endtask
`endif

    initial begin
        test_reset();
        test_rate();
        test_back_to_back();
        test_terminal_beat();
        test_meter_en();
        test_mid_reset();
`ifdef FLOW_METER_PEAK_EN
        test_peak();
`endif
        src_on = 1'b0; rdy_rand = 1'b0;
        repeat (10) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
